// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared segment patterns and anode polarity helper for the seven-segment scan driver
package sevseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [15:0][6:0] SEG_LUT = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  // Logic level that turns an anode on for the given polarity.
  function automatic logic an_level(input logic active_low);
    return ~active_low;
  endfunction

endpackage

// File: rtl/sevseg_decode.sv
// sevseg_decode: hex nibble to active-low a..g segment pattern
module sevseg_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/sevseg_scan_driver.sv
// sevseg_scan_driver: double-buffered, time-multiplexed seven-segment scanner with LZB, blanking and anode guard
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int REFRESH_DIV   = 100000,
  parameter int GUARD_CYCLES  = 16,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzb_en,
  output logic [6:0]              ca,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = NUM_DIGITS > 2 ? $clog2(NUM_DIGITS) : 1;
  localparam logic AN_ON = an_level(AN_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE = {NUM_DIGITS{~AN_ON}};

  logic [PW-1:0]                pre;
  logic [IW-1:0]                idx;
  logic                         tick, fupd, dark, guard, pend_valid;
  logic [NUM_DIGITS-1:0][3:0]   pend_dig, act_dig;
  logic [NUM_DIGITS-1:0]        pend_dp, pend_bl, act_dp, act_bl, lz, sel;
  logic [6:0]                   seg;

  assign tick  = pre == PW'(REFRESH_DIV - 1);
  assign fupd  = tick && idx == IW'(NUM_DIGITS - 1);
  assign guard = 32'(pre) < GUARD_CYCLES;
  assign sel   = NUM_DIGITS'(1) << idx;

  // lz[k]: nibbles k..top of the displayed value are all zero
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lz
    assign lz[k] = act_dig[NUM_DIGITS-1:k] == '0;
  end

  assign dark = act_bl[idx] | (lzb_en & (idx != '0) & lz[idx]);

  sevseg_decode u_dec (
    .nibble (act_dig[idx]),
    .seg    (seg)
  );

  // Slot prescaler and scanned digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
    end
  end

  // Pending/active double buffer; a load coinciding with the frame update goes straight to active
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_dig   <= '0;
      pend_dp    <= '0;
      pend_bl    <= '0;
      act_dig    <= '0;
      act_dp     <= '0;
      act_bl     <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (load) begin
        pend_dig <= digits_in;
        pend_dp  <= dp_in;
        pend_bl  <= blank_in;
      end
      if (fupd && (load || pend_valid)) begin
        act_dig <= load ? digits_in : pend_dig;
        act_dp  <= load ? dp_in : pend_dp;
        act_bl  <= load ? blank_in : pend_bl;
      end
      pend_valid <= fupd ? 1'b0 : pend_valid | load;
    end
  end

  // Registered pin outputs so segments and anodes switch on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ca          <= SEG_OFF;
      dp          <= 1'b1;
      an          <= AN_IDLE;
      frame_start <= 1'b0;
    end else begin
      ca          <= dark ? SEG_OFF : seg;
      dp          <= dark | ~act_dp[idx];
      an          <= guard ? AN_IDLE : (AN_ON ? sel : ~sel);
      frame_start <= idx == '0 && pre == '0;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// tb_sevseg_scan_driver: scoreboard bench against a cycle-count reference model of the scanner
module tb_sevseg_scan_driver;

  localparam int N  = 4;
  localparam int R  = 8;
  localparam int G  = 2;
  localparam int FR = N * R;

  typedef struct {
    int         t;
    logic       fs;
    logic [3:0] an;
    logic       dp;
    logic [6:0] ca;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blank_in;
  logic        lzb_en;
  logic [6:0]  ca;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  int          t;
  logic [15:0] m_dig, p_dig;
  logic [3:0]  m_dp, m_bl, p_dp, p_bl;
  logic        m_pv;

  logic [6:0] seg_ref [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  sevseg_scan_driver #(
    .NUM_DIGITS    (N),
    .REFRESH_DIV   (R),
    .GUARD_CYCLES  (G),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .lzb_en      (lzb_en),
    .ca          (ca),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Expected pins one edge after cycle tt of the scan (tt counted from reset release)
  function automatic exp_t expect_at(int tt);
    exp_t e;
    int slot;
    logic dk;
    slot = (tt / R) % N;
    dk = m_bl[slot] || (lzb_en && slot != 0 && (m_dig >> (4 * slot)) == 16'h0);
    e.t  = tt;
    e.fs = (tt % FR) == 0;
    e.an = (tt % R) < G ? 4'b1111 : ~(4'b0001 << slot);
    e.ca = dk ? 7'h7F : seg_ref[m_dig[4*slot +: 4]];
    e.dp = dk ? 1'b1 : ~m_dp[slot];
    return e;
  endfunction

  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    load = ld;
    digits_in = d;
    dp_in = p;
    blank_in = b;
    q.push_back(expect_at(t));
    if (t % FR == FR - 1) begin
      if (ld) {m_dig, m_dp, m_bl} = {d, p, b};
      else if (m_pv) {m_dig, m_dp, m_bl} = {p_dig, p_dp, p_bl};
      m_pv = 1'b0;
    end else if (ld) begin
      {p_dig, p_dp, p_bl} = {d, p, b};
      m_pv = 1'b1;
    end
    t++;
    @(posedge clk);
    #2;
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, digits_in, dp_in, blank_in);
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < FR && (t % FR) != ph; i++) step(1'b0, digits_in, dp_in, blank_in);
  endtask

  task automatic check_dark(input string name);
    checks++;
    if ({ca, dp, an, frame_start} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL %s got ca=%b dp=%b an=%b fs=%b exp ca=1111111 dp=1 an=1111 fs=0",
               name, ca, dp, an, frame_start);
    end
  endtask

  task automatic release_reset();
    q.delete();
    reset = 1'b0;
    t = 0;
    {m_dig, m_dp, m_bl, p_dig, p_dp, p_bl, m_pv} = '0;
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b1;
    q.delete();
    #1;
    check_dark("reset_async");
    repeat (3) @(posedge clk);
    #2;
    release_reset();
  endtask

  // Monitor: compare pins to the oldest expectation just after each active edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({frame_start, an, dp, ca} !== {e.fs, e.an, e.dp, e.ca}) begin
        errors++;
        $display("FAIL scan t=%0d got fs=%b an=%b dp=%b ca=%b exp fs=%b an=%b dp=%b ca=%b",
                 e.t, frame_start, an, dp, ca, e.fs, e.an, e.dp, e.ca);
      end
    end
  end

  initial begin
    reset = 1'b1;
    load = 1'b0;
    digits_in = '0;
    dp_in = '0;
    blank_in = '0;
    lzb_en = 1'b0;
    t = 0;
    {m_dig, m_dp, m_bl, p_dig, p_dp, p_bl, m_pv} = '0;
    #1;
    check_dark("reset_init");
    repeat (4) @(posedge clk);
    #2;
    check_dark("reset_held");
    release_reset();
    idle(3);
    step(1'b1, 16'h1A3F, 4'b0100, 4'b0000);
    idle(3 * FR);
    run_to(5);
    step(1'b1, 16'h1111, 4'b0000, 4'b0000);
    run_to(20);
    step(1'b1, 16'h2222, 4'b0000, 4'b0000);
    idle(2 * FR);
    run_to(FR - 1);
    step(1'b1, 16'h0BEE, 4'b0000, 4'b0000);
    checks++;
    if (dut.pend_valid !== 1'b0) begin
      errors++;
      $display("FAIL bypass_pending got %b exp 0", dut.pend_valid);
    end
    idle(FR + 4);
    lzb_en = 1'b1;
    step(1'b1, 16'h0005, 4'b1111, 4'b0000);
    idle(2 * FR);
    step(1'b1, 16'h0000, 4'b1111, 4'b0000);
    idle(2 * FR);
    lzb_en = 1'b0;
    step(1'b1, 16'($urandom), 4'($urandom), 4'b0010);
    idle(2 * FR);
    run_to(2 * R + 4);
    mid_reset();
    idle(FR);
    step(1'b1, 16'($urandom), 4'($urandom), 4'b0010);
    idle(2 * FR);
    repeat (40) begin
      lzb_en = 1'($urandom_range(0, 1));
      step(1'b1, 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom),
           4'($urandom), 4'($urandom_range(0, 2) == 0 ? $urandom : 0));
      idle($urandom_range(0, 40));
    end
    idle(FR);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
